cpu_axim_master: RTL and testbench
==================================

Name: cpu_axim_master

Overview:
- Simple CPU-side AXI4-Lite master that performs one single-beat write or read per command.
- Commands come from a control/test interface (start pulses, type, address, data). The block drives the five AXI-Lite channels to a memory slave and pulses test_done when the transaction completes.
- Sits at the top of the SoC bus as the only master.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with AXIM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset; synchronous, active-high (1 = reset asserted).
- start_test  in  1  launch the command selected by ins_type.
- ins_type  in  2  00 = WRITE_MEM, 01 = READ_MEM, 10/11 reserved.
- address  in  ADDR_WIDTH  target address.
- data_to_write  in  DATA_WIDTH  write payload.
- start_write  in  1  launch a write regardless of ins_type.
- start_read  in  1  launch a read regardless of ins_type.
- test_done  out  1  one-cycle completion pulse.
- rd_data  out  DATA_WIDTH  last read data, held until the next read completes.
- resp_err  out  1  last B/R response was not OKAY (or timed out).
- M_AXI_AWADDR out ADDR_WIDTH; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out DATA_WIDTH; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_WIDTH; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in DATA_WIDTH; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Reset values: all VALID/READY outputs 0, AWADDR/WDATA/ARADDR 0, rd_data 0, resp_err 0, test_done 0, FSM in IDLE. All outputs are registered.
- States: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA.
- Launch (IDLE only), with priority start_write > start_read > start_test:
  - start_test with ins_type 00 is a write; with 01 it is a read; with 10/11 it is ignored and the FSM stays IDLE.
  - address and data_to_write are latched at the launch edge.
  - Start inputs in any non-IDLE state are ignored; there is no queueing.
- Write path:
  - Launch edge → IDLE to WR; AWVALID=1 and WVALID=1 from the next cycle, with AWADDR/WDATA set to the latched values.
  - Each VALID drops on the edge where its own handshake occurs (VALID&READY), so AW and W are handled independently and in any order.
  - When both handshakes are done → WR_RESP with BREADY=1.
  - On BVALID&BREADY: BREADY→0, resp_err←(BRESP!=00), test_done=1 for one cycle, back to IDLE.
  - Minimum latency with always-ready slave: launch edge → AW/W handshake at edge+1 → BVALID (slave-dependent).
- Read path:
  - Launch → RD_ADDR with ARVALID=1 and ARADDR latched.
  - On ARVALID&ARREADY → RD_DATA with RREADY=1.
  - On RVALID&RREADY: rd_data←RDATA, resp_err←(RRESP!=00), test_done pulse, IDLE.
- AXI rules:
  - VALID is never deasserted before its handshake.
  - ADDR/DATA stay stable while VALID is high.
  - VALID never depends combinationally on READY.
- Reset mid-transaction: at the next edge all VALID/READY→0 and FSM→IDLE; no test_done; rd_data/resp_err cleared.
- test_done is exactly one cycle per completed transaction and never asserts in IDLE without a transaction.

Optional Feature:
- Macro AXIM_TIMEOUT_EN.
- When defined: a counter runs in every non-IDLE state and resets on each handshake. On reaching TIMEOUT_CYCLES, all VALID/READY→0, resp_err←1, test_done pulses, and the FSM returns to IDLE.
- When undefined: no counter; the FSM waits indefinitely for the slave.

Test Plan:
- Reset 2 cycles, then start_write with address=0x10, data_to_write=0xDEADBEEF, always-ready slave → next cycle AWADDR=0x10, WDATA=0xDEADBEEF, AWVALID=WVALID=1; BREADY after handshake; BRESP=00 → single test_done pulse, resp_err=0.
- Then start_read with ins_type=01, address=0x10 → ARADDR=0x10; RDATA=0xDEADBEEF, RRESP=00 → rd_data=0xDEADBEEF, test_done pulse.
- Write with AWREADY delayed 3 cycles and WREADY immediate → WVALID drops after 1 cycle; AWVALID held with AWADDR stable until handshake; exactly one test_done.
- Slave returns BRESP=10 → resp_err=1; next OKAY read → resp_err=0.
- start_read asserted while a write is in flight, and start_test with ins_type=10 in IDLE → both ignored, no AR activity, no extra test_done.
- rstn asserted while ARVALID=1 → next edge ARVALID=0, FSM IDLE, no test_done. With AXIM_TIMEOUT_EN and BVALID never asserted → test_done pulse and resp_err=1 after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/cpu_axim_master.sv
// cpu_axim_master: single-beat AXI4-Lite master driven by CPU-side start pulses.
// Optional build macro AXIM_TIMEOUT_EN adds a watchdog. When the slave makes no
// handshake for TIMEOUT_CYCLES cycles, the watchdog aborts the transaction with resp_err=1.
module cpu_axim_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_test,
    input  logic [1:0]            ins_type,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_to_write,
    input  logic                  start_write,
    input  logic                  start_read,
    output logic                  test_done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t r_state;
    logic   w_launch_wr;
    logic   w_launch_rd;
    logic   w_aw_done;
    logic   w_w_done;

`ifdef AXIM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             w_hs;
`endif

    // launch decode with priority start_write > start_read > start_test; a channel is done once its VALID is low or accepted now
    always_comb begin
        w_launch_wr = start_write | (~start_read & start_test & (ins_type == 2'b00));
        w_launch_rd = ~start_write & (start_read | (start_test & (ins_type == 2'b01)));
        w_aw_done   = ~M_AXI_AWVALID | M_AXI_AWREADY;
        w_w_done    = ~M_AXI_WVALID | M_AXI_WREADY;
`ifdef AXIM_TIMEOUT_EN
        w_hs = (M_AXI_AWVALID & M_AXI_AWREADY) | (M_AXI_WVALID & M_AXI_WREADY) |
               (M_AXI_BVALID & M_AXI_BREADY) | (M_AXI_ARVALID & M_AXI_ARREADY) |
               (M_AXI_RVALID & M_AXI_RREADY);
`endif
    end

    // transaction FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state       <= IDLE;
            test_done     <= 1'b0;
            rd_data       <= '0;
            resp_err      <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
`ifdef AXIM_TIMEOUT_EN
            r_cnt         <= '0;
`endif
        end else begin
            test_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_launch_wr) begin
                        r_state       <= WR;
                        M_AXI_AWADDR  <= address;
                        M_AXI_WDATA   <= data_to_write;
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID  <= 1'b1;
                    end else if (w_launch_rd) begin
                        r_state       <= RD_ADDR;
                        M_AXI_ARADDR  <= address;
                        M_AXI_ARVALID <= 1'b1;
                    end
                end
                WR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_state      <= WR_RESP;
                        M_AXI_BREADY <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_state      <= IDLE;
                        M_AXI_BREADY <= 1'b0;
                        resp_err     <= |M_AXI_BRESP;
                        test_done    <= 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        r_state       <= RD_DATA;
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        r_state      <= IDLE;
                        M_AXI_RREADY <= 1'b0;
                        rd_data      <= M_AXI_RDATA;
                        resp_err     <= |M_AXI_RRESP;
                        test_done    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
`ifdef AXIM_TIMEOUT_EN
            if (r_state == IDLE || w_hs) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                r_cnt         <= '0;
                r_state       <= IDLE;
                M_AXI_AWVALID <= 1'b0;
                M_AXI_WVALID  <= 1'b0;
                M_AXI_BREADY  <= 1'b0;
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b0;
                resp_err      <= 1'b1;
                test_done     <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_cpu_axim_master.sv
// tb_cpu_axim_master: directed vectors plus hand sequences against a delay-configurable AXI-Lite slave model.
module tb_cpu_axim_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start_test = 1'b0, start_write = 1'b0, start_read = 1'b0;
    logic [1:0]    ins_type = 2'b00;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_to_write = '0;
    logic          test_done, resp_err;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] awaddr, araddr;
    logic [DW-1:0] wdata;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [1:0]    bresp, rresp;
    logic [DW-1:0] rdata;

    int            checks = 0, errors = 0;

    int            cfg_a_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
    logic [1:0]    cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [DW-1:0] cfg_rdata = '0;
    bit            cfg_b_never = 0;

    int            aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_wait = 0, r_wait = 0;
    bit            aw_seen = 0, w_seen = 0, ar_seen = 0;
    int            aw_hs = 0, ar_hs = 0, done_cnt = 0;
    logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
    logic [DW-1:0] cap_wdata = '0;
    bit            aw_pend = 0, w_pend = 0, ar_pend = 0, stab_bad = 0;
    logic [AW-1:0] prev_awaddr = '0, prev_araddr = '0;
    logic [DW-1:0] prev_wdata = '0;

    always #5 clk = ~clk;

    cpu_axim_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn), .start_test(start_test), .ins_type(ins_type),
        .address(address), .data_to_write(data_to_write),
        .start_write(start_write), .start_read(start_read),
        .test_done(test_done), .rd_data(rd_data), .resp_err(resp_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    assign awready = awvalid && (aw_cnt >= cfg_a_dly);
    assign wready  = wvalid && (w_cnt >= cfg_w_dly);
    assign arready = arvalid && (ar_cnt >= cfg_a_dly);
    assign bresp   = cfg_bresp;
    assign rresp   = cfg_rresp;
    assign rdata   = cfg_rdata;

    // slave model: READY after a per-channel wait, B/R after both requests seen plus a delay
    always @(posedge clk) begin
        if (awvalid && awready) begin aw_hs <= aw_hs + 1; cap_awaddr <= awaddr; end
        if (arvalid && arready) begin ar_hs <= ar_hs + 1; cap_araddr <= araddr; end
        if (wvalid && wready) cap_wdata <= wdata;
        if (test_done) done_cnt <= done_cnt + 1;
        if (rstn) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_wait <= 0; r_wait <= 0;
            aw_seen <= 0; w_seen <= 0; ar_seen <= 0; bvalid <= 0; rvalid <= 0;
        end else begin
            aw_cnt <= awvalid ? aw_cnt + 1 : 0;
            w_cnt  <= wvalid ? w_cnt + 1 : 0;
            ar_cnt <= arvalid ? ar_cnt + 1 : 0;
            if (awvalid && awready) aw_seen <= 1;
            if (wvalid && wready) w_seen <= 1;
            if (arvalid && arready) ar_seen <= 1;
            if (bvalid && bready) begin
                bvalid <= 0; aw_seen <= 0; w_seen <= 0; b_wait <= 0;
            end else if (aw_seen && w_seen && !bvalid && !cfg_b_never) begin
                if (b_wait >= cfg_b_dly) bvalid <= 1; else b_wait <= b_wait + 1;
            end
            if (rvalid && rready) begin
                rvalid <= 0; ar_seen <= 0; r_wait <= 0;
            end else if (ar_seen && !rvalid) begin
                if (r_wait >= cfg_w_dly) rvalid <= 1; else r_wait <= r_wait + 1;
            end
        end
    end

    // protocol monitor: a pending VALID must stay high with stable payload
    always @(posedge clk) begin
        if (aw_pend && (!awvalid || awaddr !== prev_awaddr)) stab_bad <= 1;
        if (w_pend && (!wvalid || wdata !== prev_wdata)) stab_bad <= 1;
        if (ar_pend && (!arvalid || araddr !== prev_araddr)) stab_bad <= 1;
        aw_pend <= !rstn && awvalid && !awready;
        w_pend  <= !rstn && wvalid && !wready;
        ar_pend <= !rstn && arvalid && !arready;
        prev_awaddr <= awaddr;
        prev_wdata  <= wdata;
        prev_araddr <= araddr;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic launch(input bit sw, input bit sr, input bit st, input logic [1:0] ins,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        start_write = sw; start_read = sr; start_test = st;
        ins_type = ins; address = a; data_to_write = d;
        @(negedge clk);
        start_write = 0; start_read = 0; start_test = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!test_done && n < budget) begin @(negedge clk); n++; end
        chk({name, "_done_seen"}, test_done, 1'b1);
    endtask

    typedef struct {
        bit sw, sr, st;
        logic [1:0] ins;
        logic [31:0] addr, data;
        int a_dly, w_dly, b_dly;
        logic [1:0] bresp;
        logic [31:0] rdata;
        logic [1:0] rresp;
        bit exp_wr, exp_rd;
        logic exp_err;
        logic [31:0] exp_rd_data;
    } vec_t;

    vec_t vt[11];

    initial begin
        int d0, a0, r0;
        vt[0]  = '{0, 0, 1, 2'b01, 32'h10, 32'h0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 2'b00, 0, 1, 1'b0, 32'hDEADBEEF};
        vt[1]  = '{1, 0, 0, 2'b00, 32'h20, 32'h11111111, 3, 0, 0, 2'b00, 32'h0, 2'b00, 1, 0, 1'b0, 32'hDEADBEEF};
        vt[2]  = '{1, 0, 0, 2'b00, 32'h24, 32'h22222222, 0, 0, 1, 2'b10, 32'h0, 2'b00, 1, 0, 1'b1, 32'hDEADBEEF};
        vt[3]  = '{0, 1, 0, 2'b00, 32'h20, 32'h0, 1, 2, 0, 2'b00, 32'h12345678, 2'b00, 0, 1, 1'b0, 32'h12345678};
        vt[4]  = '{0, 0, 1, 2'b10, 32'h28, 32'h33, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0, 0, 1'b0, 32'h12345678};
        vt[5]  = '{0, 0, 1, 2'b00, 32'h44, 32'hA5A5A5A5, 0, 2, 2, 2'b01, 32'h0, 2'b00, 1, 0, 1'b1, 32'h12345678};
        vt[6]  = '{0, 1, 0, 2'b00, 32'h30, 32'h0, 0, 0, 0, 2'b00, 32'hCAFEF00D, 2'b11, 0, 1, 1'b1, 32'hCAFEF00D};
        vt[7]  = '{0, 0, 1, 2'b11, 32'h34, 32'h0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0, 0, 1'b1, 32'hCAFEF00D};
        vt[8]  = '{1, 1, 0, 2'b00, 32'h50, 32'h0BADF00D, 0, 0, 0, 2'b00, 32'h0, 2'b00, 1, 0, 1'b0, 32'hCAFEF00D};
        vt[9]  = '{0, 1, 1, 2'b00, 32'h54, 32'h0, 0, 1, 0, 2'b00, 32'h00C0FFEE, 2'b00, 0, 1, 1'b0, 32'h00C0FFEE};
        vt[10] = '{1, 0, 1, 2'b01, 32'h58, 32'h00000005, 2, 1, 0, 2'b00, 32'h0, 2'b00, 1, 0, 1'b0, 32'h00C0FFEE};

        // reset for two cycles, then all outputs idle
        repeat (2) @(negedge clk);
        rstn = 0;
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_test_done", test_done, 0);

        // first write, cycle accurate against an always-ready slave
        d0 = done_cnt;
        launch(1, 0, 0, 2'b00, 32'h10, 32'hDEADBEEF);
        chk("w1_awvalid", awvalid, 1);
        chk("w1_wvalid", wvalid, 1);
        chk("w1_awaddr", awaddr, 32'h10);
        chk("w1_wdata", wdata, 32'hDEADBEEF);
        chk("w1_bready_early", bready, 0);
        @(negedge clk);
        chk("w1_awvalid_drop", awvalid, 0);
        chk("w1_wvalid_drop", wvalid, 0);
        chk("w1_bready", bready, 1);
        wait_done("w1", 20);
        chk("w1_resp_err", resp_err, 0);
        @(negedge clk);
        chk("w1_done_one_cycle", test_done, 0);
        chk("w1_done_count", done_cnt - d0, 1);

        // table of complete transactions
        foreach (vt[i]) begin
            d0 = done_cnt; a0 = aw_hs; r0 = ar_hs;
            cfg_a_dly = vt[i].a_dly; cfg_w_dly = vt[i].w_dly; cfg_b_dly = vt[i].b_dly;
            cfg_bresp = vt[i].bresp; cfg_rdata = vt[i].rdata; cfg_rresp = vt[i].rresp;
            launch(vt[i].sw, vt[i].sr, vt[i].st, vt[i].ins, vt[i].addr, vt[i].data);
            repeat (25) @(negedge clk);
            chk($sformatf("v%0d_done", i), done_cnt - d0, (vt[i].exp_wr || vt[i].exp_rd) ? 1 : 0);
            chk($sformatf("v%0d_aw_hs", i), aw_hs - a0, vt[i].exp_wr ? 1 : 0);
            chk($sformatf("v%0d_ar_hs", i), ar_hs - r0, vt[i].exp_rd ? 1 : 0);
            chk($sformatf("v%0d_resp_err", i), resp_err, vt[i].exp_err);
            chk($sformatf("v%0d_rd_data", i), rd_data, vt[i].exp_rd_data);
            if (vt[i].exp_wr) begin
                chk($sformatf("v%0d_awaddr", i), cap_awaddr, vt[i].addr);
                chk($sformatf("v%0d_wdata", i), cap_wdata, vt[i].data);
            end
            if (vt[i].exp_rd) chk($sformatf("v%0d_araddr", i), cap_araddr, vt[i].addr);
        end

        // AW delayed three cycles, W accepted at once
        cfg_a_dly = 3; cfg_w_dly = 0; cfg_b_dly = 0; cfg_bresp = 2'b00;
        d0 = done_cnt;
        launch(1, 0, 0, 2'b00, 32'h60, 32'h66);
        chk("dly_wvalid_c1", wvalid, 1);
        @(negedge clk);
        chk("dly_wvalid_c2", wvalid, 0);
        chk("dly_awvalid_c2", awvalid, 1);
        @(negedge clk);
        chk("dly_awvalid_c3", awvalid, 1);
        @(negedge clk);
        chk("dly_awvalid_c4", awvalid, 1);
        chk("dly_awaddr_c4", awaddr, 32'h60);
        @(negedge clk);
        chk("dly_awvalid_c5", awvalid, 0);
        repeat (15) @(negedge clk);
        chk("dly_done_count", done_cnt - d0, 1);

        // start inputs while a write is in flight are ignored
        cfg_a_dly = 0; cfg_b_dly = 4;
        d0 = done_cnt; a0 = aw_hs; r0 = ar_hs;
        launch(1, 0, 0, 2'b00, 32'h70, 32'h77);
        start_read = 1; address = 32'h99;
        @(negedge clk);
        start_read = 0; start_test = 1; ins_type = 2'b01;
        @(negedge clk);
        start_test = 0;
        repeat (20) @(negedge clk);
        chk("busy_ar_hs", ar_hs - r0, 0);
        chk("busy_aw_hs", aw_hs - a0, 1);
        chk("busy_done_count", done_cnt - d0, 1);
        chk("busy_awaddr", cap_awaddr, 32'h70);

        // reset while ARVALID is waiting for the slave
        cfg_a_dly = 10; cfg_b_dly = 0;
        d0 = done_cnt;
        launch(0, 1, 0, 2'b00, 32'h80, 32'h0);
        chk("rstmid_arvalid_before", arvalid, 1);
        chk("rstmid_araddr", araddr, 32'h80);
        rstn = 1;
        @(negedge clk);
        rstn = 0;
        chk("rstmid_arvalid_after", arvalid, 0);
        chk("rstmid_test_done", test_done, 0);
        chk("rstmid_rd_data", rd_data, 0);
        chk("rstmid_resp_err", resp_err, 0);
        repeat (10) @(negedge clk);
        chk("rstmid_done_count", done_cnt - d0, 0);

`ifdef AXIM_TIMEOUT_EN
        // slave never answers on B: the watchdog must end the write
        cfg_a_dly = 0; cfg_b_never = 1;
        d0 = done_cnt;
        launch(1, 0, 0, 2'b00, 32'h90, 32'h99);
        wait_done("tmo", TO + 40);
        chk("tmo_resp_err", resp_err, 1);
        @(negedge clk);
        chk("tmo_bready", bready, 0);
        chk("tmo_done_count", done_cnt - d0, 1);
`endif

        chk("valid_stability", stab_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
